// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Scanner state encoding, column drive patterns and key code layout.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_t;

  typedef struct packed {
    logic [1:0] row;
    logic [1:0] col;
  } key_t;

  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  function automatic logic [3:0] col_drive(
    input logic [1:0] idx
  );
    logic [3:0] pat;
    pat = COL_0;
    unique case (idx)
      2'd0: pat = COL_0;
      2'd1: pat = COL_1;
      2'd2: pat = COL_2;
      2'd3: pat = COL_3;
    endcase
    return pat;
  endfunction

  // Several rows low at once resolve to the lowest row index.
  function automatic logic [1:0] low_row(
    input logic [3:0] rows
  );
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones (rows idle high).
module keypad_sync (
  input  logic       system_clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Define KEYPAD_REPEAT_EN to enable auto-repeat of a held key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000,
  parameter int unsigned REPEAT_DLY   = 5000000
) (
  input  logic       system_clk,
  input  logic       rst_n,
  input  logic [3:0] pad_row,
  output logic [3:0] pad_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CNT - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DLY - 1);

`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  kp_state_t     state;
  logic [3:0]    row_s;
  logic [3:0]    row_lat;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [DW-1:0] div;
  logic [BW-1:0] stab;
  logic [RW-1:0] rep;
  key_t          key_q;

  keypad_sync u_sync (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .d          (pad_row),
    .q          (row_s)
  );

  assign pad_col  = col_drive(col_idx);
  assign key_code = key_q;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      row_lat   <= 4'hF;
      row_idx   <= '0;
      col_idx   <= '0;
      div       <= '0;
      stab      <= '0;
      rep       <= '0;
      key_q     <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (div == DIV_LAST) begin
            div <= '0;
            if (!(&row_s)) begin
              state   <= DEBOUNCE;
              row_lat <= row_s;
              row_idx <= low_row(row_s);
              stab    <= '0;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s == row_lat) begin
            if (stab == DEB_LAST) begin
              state     <= PRESSED;
              key_q     <= '{row: row_idx, col: col_idx};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rep       <= '0;
            end else begin
              stab <= stab + 1'b1;
            end
          end else begin
            state   <= SCAN;
            col_idx <= col_idx + 2'd1;
            div     <= '0;
            stab    <= '0;
          end
        end
        PRESSED: begin
          if (&row_s) begin
            state <= RELEASE;
            stab  <= '0;
            rep   <= '0;
          end else if (rep == REP_LAST) begin
            rep       <= '0;
            key_valid <= REPEAT_ON;
          end else begin
            rep <= rep + 1'b1;
          end
        end
        RELEASE: begin
          // Any row low before the release settles means the key bounced.
          if (&row_s) begin
            if (stab == DEB_LAST) begin
              state    <= SCAN;
              key_held <= 1'b0;
              col_idx  <= col_idx + 2'd1;
              div      <= '0;
              stab     <= '0;
            end else begin
              stab <= stab + 1'b1;
            end
          end else begin
            state <= PRESSED;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: keypad matrix model,
// directed scenarios, random presses and a reference model.
module tb_keypad_scan;

  localparam int SD  = 4;
  localparam int DEB = 8;
  localparam int RD  = 32;

`ifdef KEYPAD_REPEAT_EN
  localparam bit REP_EN  = 1'b1;
  localparam int EXP_REP = 3;
`else
  localparam bit REP_EN  = 1'b0;
  localparam int EXP_REP = 0;
`endif

  localparam int M_SCAN = 0;
  localparam int M_DEB  = 1;
  localparam int M_HOLD = 2;
  localparam int M_REL  = 3;

  logic        system_clk = 1'b0;
  logic        rst_n      = 1'b1;
  logic [3:0]  pad_row;
  logic [3:0]  pad_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] key_mask = '0;
  logic        gl_high  = 1'b0;

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_valid = 0;
  logic [3:0]  last_code = '0;

  int          m_mode, m_slot, m_col, m_row, m_stable, m_rep;
  logic [3:0]  m_s1, m_s2, m_pat, m_code;
  logic        m_valid, m_held;

  keypad_scan #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CNT (DEB),
    .REPEAT_DLY   (RD)
  ) dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .pad_row    (pad_row),
    .pad_col    (pad_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 system_clk = ~system_clk;

  // Matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    pad_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_mask[r*4+c] && !pad_col[c]) pad_row[r] = 1'b0;
    if (gl_high) pad_row = 4'hF;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_pat = 4'hF;
    m_mode = M_SCAN; m_slot = 0; m_col = 0; m_row = 0;
    m_stable = 0; m_rep = 0; m_code = '0;
    m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] rows;
    rows = m_s2;
    m_s2 = m_s1;
    m_s1 = pad_row;
    m_valid = 1'b0;
    case (m_mode)
      M_SCAN: begin
        if (m_slot == SD - 1) begin
          m_slot = 0;
          if (rows != 4'hF) begin
            m_mode = M_DEB;
            m_pat = rows;
            m_stable = 0;
            for (int r = 3; r >= 0; r--) if (!rows[r]) m_row = r;
          end else m_col = (m_col + 1) % 4;
        end else m_slot++;
      end
      M_DEB: begin
        if (rows == m_pat) begin
          m_stable++;
          if (m_stable == DEB) begin
            m_mode = M_HOLD;
            m_code = 4'(m_row * 4 + m_col);
            m_valid = 1'b1;
            m_held = 1'b1;
            m_rep = 0;
          end
        end else begin
          m_mode = M_SCAN;
          m_col = (m_col + 1) % 4;
          m_slot = 0;
          m_stable = 0;
        end
      end
      M_HOLD: begin
        if (rows == 4'hF) begin
          m_mode = M_REL;
          m_stable = 0;
          m_rep = 0;
        end else begin
          m_rep++;
          if (m_rep == RD) begin
            m_rep = 0;
            m_valid = REP_EN;
          end
        end
      end
      default: begin
        if (rows == 4'hF) begin
          m_stable++;
          if (m_stable == DEB) begin
            m_mode = M_SCAN;
            m_held = 1'b0;
            m_col = (m_col + 1) % 4;
            m_slot = 0;
            m_stable = 0;
          end
        end else begin
          m_mode = M_HOLD;
          m_stable = 0;
        end
      end
    endcase
  endtask

  always @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge system_clk) begin
    if (rst_n) begin
      chk("pad_col", pad_col, 4'hF ^ (4'd1 << m_col));
      chk("key_valid", key_valid, m_valid);
      chk("key_held", key_held, m_held);
      chk("key_code", key_code, m_code);
      if (key_valid) begin
        n_valid   <= n_valid + 1;
        last_code <= key_code;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge system_clk);
  endtask

  task automatic wait_held(input logic lvl, input string tag);
    int i;
    i = 0;
    while (key_held !== lvl && i < 300) begin
      @(negedge system_clk);
      i++;
    end
    chk(tag, key_held, lvl);
  endtask

  task automatic wait_mode(input int mode, input int stab, input string tag);
    int i;
    i = 0;
    while (!(m_mode == mode && m_stable >= stab) && i < 300) begin
      @(negedge system_clk);
      i++;
    end
    chk(tag, m_mode, mode);
  endtask

  initial begin
    int v0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col", pad_col, 4'b1110);
    chk("rst_code", key_code, 4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held", key_held, 1'b0);
    cycles(3);
    rst_n = 1'b1;

    // Idle scan: column walks every SD cycles.
    v0 = n_valid;
    for (int k = 0; k <= 4; k++) begin
      chk("idle_col", pad_col, 4'hF ^ (4'd1 << (k % 4)));
      cycles(SD);
    end
    cycles(20);
    chk("idle_nvalid", n_valid - v0, 0);

    // Row 2 / col 1 single press and release.
    v0 = n_valid;
    key_mask = 16'(1 << (2*4 + 1));
    wait_held(1'b1, "r2c1_accept");
    cycles(20);
    chk("r2c1_held", key_held, 1'b1);
    key_mask = '0;
    wait_held(1'b0, "r2c1_release");
    cycles(2);
    chk("r2c1_nvalid", n_valid - v0, 1);
    chk("r2c1_code", last_code, 4'h9);

    // Bounce after 3 stable debounce cycles.
    cycles(10);
    v0 = n_valid;
    key_mask = 16'(1 << (2*4 + 1));
    wait_mode(M_DEB, 3, "bounce_deb");
    key_mask = '0;
    wait_mode(M_SCAN, 0, "bounce_scan");
    cycles(1);
    chk("bounce_col", pad_col, 4'b1011);
    cycles(20);
    chk("bounce_nvalid", n_valid - v0, 0);

    // Rows 1 and 3 on col 0 resolve to row 1.
    key_mask = 16'((1 << (1*4)) | (1 << (3*4)));
    wait_held(1'b1, "multi_accept");
    cycles(2);
    chk("multi_code", last_code, 4'h4);
    key_mask = '0;
    wait_held(1'b0, "multi_release");

    // Short release glitch while releasing.
    v0 = n_valid;
    key_mask = 16'(1 << (0*4 + 3));
    wait_held(1'b1, "glitch_accept");
    cycles(5);
    key_mask = '0;
    wait_mode(M_REL, 2, "glitch_rel");
    key_mask = 16'(1 << (0*4 + 3));
    cycles(3);
    key_mask = '0;
    chk("glitch_held", key_held, 1'b1);
    wait_held(1'b0, "glitch_release");
    cycles(2);
    chk("glitch_nvalid", n_valid - v0, 1);
    chk("glitch_code", last_code, 4'h3);

    // Reset while a key is held.
    key_mask = 16'(1 << (3*4 + 2));
    wait_held(1'b1, "rst_accept");
    cycles(5);
    rst_n = 1'b0;
    #1;
    chk("rstp_held", key_held, 1'b0);
    chk("rstp_col", pad_col, 4'b1110);
    chk("rstp_code", key_code, 4'h0);
    cycles(3);
    v0 = n_valid;
    rst_n = 1'b1;
    cycles(2);
    chk("rstp_nvalid", n_valid - v0, 0);
    wait_held(1'b1, "rstp_reaccept");
    key_mask = '0;
    wait_held(1'b0, "rstp_release");

    // Key held 100 cycles after acceptance.
    cycles(5);
    v0 = n_valid;
    key_mask = 16'(1 << (1*4 + 2));
    wait_held(1'b1, "rep_accept");
    cycles(100);
    key_mask = '0;
    wait_held(1'b0, "rep_release");
    cycles(2);
    chk("rep_nvalid", n_valid - v0, 1 + EXP_REP);

    // Random presses with random bounce glitches.
    for (int it = 0; it < 40; it++) begin
      int dur;
      key_mask = 16'(1 << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        key_mask = key_mask | 16'(1 << $urandom_range(0, 15));
      dur = $urandom_range(0, 60);
      for (int k = 0; k < dur; k++) begin
        gl_high = ($urandom_range(0, 7) == 0);
        @(negedge system_clk);
      end
      gl_high = 1'b0;
      key_mask = '0;
      cycles($urandom_range(0, 30));
    end
    wait_held(1'b0, "rand_idle");
    cycles(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
